// File: rtl/aging_vec_pkg.sv
// Shared types, constants and helper functions for the aging vector player.
// Holds the FSM state encoding plus the response fold and MISR step functions.
package aging_vec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int          SIG_W     = 32;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;
  // Widest response the fold accepts; callers zero-extend into this width.
  localparam int          FOLD_MAX  = 4096;

  // XOR of the low `width` bits taken as zero-padded 32-bit chunks.
  function automatic logic [SIG_W-1:0] fold(input logic [FOLD_MAX-1:0] data,
                                            input int width);
    logic [FOLD_MAX-1:0] rest;
    logic [SIG_W-1:0]    acc;
    rest = data;
    acc  = '0;
    for (int c = 0; c < FOLD_MAX / SIG_W; c++) begin
      if (c * SIG_W < width) begin
        acc = acc ^ rest[SIG_W-1:0];
      end else begin
        acc = acc;
      end
      rest = rest >> SIG_W;
    end
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : 32'h0000_0000) ^ f;
  endfunction

endpackage

// File: rtl/aging_vec_player_misr32.sv
// 32-bit multiple-input signature register compacting folded responses.
// clr reloads the seed and takes priority over en.
module misr32
  import aging_vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    if (clr) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, data);
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aging_vec_player.sv
// Replays a loaded vector table into a combinational benchmark with a fixed
// settle time and loop count, capturing each response into a MISR signature.
module aging_vec_player
  import aging_vec_pkg::*;
#(
  parameter int  IN_W   = 233,
  parameter int  OUT_W  = 140,
  parameter int  DEPTH  = 8,
  parameter int  SETTLE = 1,
  parameter int  LOOP_W = 16,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [IN_W-1:0]   load_data,
  input  logic              start,
  input  logic              abort,
  input  logic [AW:0]       num_vec,
  input  logic [LOOP_W-1:0] loops,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              cap_valid,
  output logic [OUT_W-1:0]  cap_data,
  output logic [AW-1:0]     vec_idx,
  output logic [31:0]       cap_count,
  output logic [31:0]       signature
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [IN_W-1:0]   tbl_q [DEPTH];
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     vec_idx_q, vec_idx_d;
  logic [AW:0]       num_vec_q, num_vec_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic [OUT_W-1:0]  cap_data_q, cap_data_d;
  logic [31:0]       cap_count_q, cap_count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cap_valid_q, cap_valid_d;
  logic              tbl_we_s, start_ok_s, last_vec_s;
  logic              sig_clr_s, sig_en_s;
  logic [SIG_W-1:0]  fold_s;

  assign tbl_we_s   = load_we && (state_q == ST_IDLE);
  assign start_ok_s = start && !abort && (num_vec != '0) && (num_vec <= DEPTH_C);
  assign last_vec_s = ((AW+1)'(ptr_q) + (AW+1)'(1)) >= num_vec_q;
  assign fold_s     = fold(FOLD_MAX'(dut_out), OUT_W);

  // The table has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      tbl_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    vec_idx_d   = vec_idx_q;
    num_vec_d   = num_vec_q;
    loops_d     = loops_q;
    cnt_d       = cnt_q;
    dut_in_d    = dut_in_q;
    cap_data_d  = cap_data_q;
    cap_count_d = cap_count_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cap_valid_d = 1'b0;
    sig_clr_s   = 1'b0;
    sig_en_s    = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok_s) begin
            state_d     = ST_APPLY;
            ptr_d       = '0;
            vec_idx_d   = '0;
            cap_count_d = 32'd0;
            sig_clr_s   = 1'b1;
            num_vec_d   = num_vec;
            loops_d     = (loops == '0) ? LOOP_W'(1) : loops;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_APPLY: begin
          busy_d    = 1'b1;
          dut_in_d  = tbl_q[ptr_q];
          vec_idx_d = ptr_q;
          cnt_d     = SETTLE_C;
          state_d   = (SETTLE_C == 8'd1) ? ST_CAPTURE : ST_WAIT;
        end
        ST_WAIT: begin
          busy_d = 1'b1;
          cnt_d  = cnt_q - 8'd1;
          // Leaving at 2 means the counter shows 1 as CAPTURE is entered.
          if (cnt_q <= 8'd2) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_CAPTURE: begin
          busy_d      = 1'b1;
          cap_valid_d = 1'b1;
          cap_data_d  = dut_out;
          cap_count_d = cap_count_q + 32'd1;
          sig_en_s    = 1'b1;
          if (last_vec_s) begin
            ptr_d = '0;
            if (loops_q > LOOP_W'(1)) begin
              loops_d = loops_q - LOOP_W'(1);
              state_d = ST_APPLY;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ST_APPLY;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      vec_idx_q   <= '0;
      num_vec_q   <= '0;
      loops_q     <= '0;
      cnt_q       <= 8'd0;
      dut_in_q    <= '0;
      cap_data_q  <= '0;
      cap_count_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      vec_idx_q   <= vec_idx_d;
      num_vec_q   <= num_vec_d;
      loops_q     <= loops_d;
      cnt_q       <= cnt_d;
      dut_in_q    <= dut_in_d;
      cap_data_q  <= cap_data_d;
      cap_count_q <= cap_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  misr32 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sig_clr_s),
    .en    (sig_en_s),
    .data  (fold_s),
    .sig   (signature)
  );

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign vec_idx   = vec_idx_q;
  assign cap_count = cap_count_q;

endmodule

// File: tb/tb_aging_vec_player.sv
// Randomized self-checking bench for aging_vec_player driving a c17-based
// benchmark; expectations come from a cycle-count and MISR reference model.
module tb_aging_vec_player;

  localparam int IN_W   = 48;
  localparam int OUT_W  = 40;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 3;
  localparam int LOOP_W = 16;
  localparam int AW     = 3;
  localparam int NO     = 1000000;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [IN_W-1:0]   load_data;
  logic              start;
  logic              abort;
  logic [AW:0]       num_vec;
  logic [LOOP_W-1:0] loops;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              busy, done, cap_valid;
  logic [OUT_W-1:0]  cap_data;
  logic [AW-1:0]     vec_idx;
  logic [31:0]       cap_count, signature;

  int n_vec = 0;
  int n_bad = 0;
  logic [IN_W-1:0] tbl_m [DEPTH];
  logic [31:0] last_sig_m;
  int          last_cnt_m;

  aging_vec_player #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE), .LOOP_W(LOOP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .abort(abort), .num_vec(num_vec),
    .loops(loops), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
    .done(done), .cap_valid(cap_valid), .cap_data(cap_data),
    .vec_idx(vec_idx), .cap_count(cap_count), .signature(signature)
  );

  always #5 clk = ~clk;

  // Benchmark under stress: c17 on the low five inputs plus a wide XOR cone.
  function automatic logic [OUT_W-1:0] bench_f(input logic [IN_W-1:0] x);
    logic n10, n11, n16, n19, n22, n23;
    n10 = ~(x[0] & x[2]);
    n11 = ~(x[2] & x[3]);
    n16 = ~(x[1] & n11);
    n19 = ~(n11 & x[4]);
    n22 = ~(n10 & n16);
    n23 = ~(n16 & n19);
    return {x[47:10] ^ x[37:0], n23, n22};
  endfunction

  assign dut_out = bench_f(dut_in);

  function automatic logic [31:0] sw_misr(input logic [31:0] s, input logic [OUT_W-1:0] r);
    logic [63:0] padded;
    logic [31:0] f;
    padded = 64'(r);
    f = padded[31:0] ^ padded[63:32];
    return (s << 1) ^ ((s >> 31) * POLY) ^ f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_dut_in"}, 64'(dut_in), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_capv"}, 64'(cap_valid), 64'd0);
    chk({tag, "_capd"}, 64'(cap_data), 64'd0);
    chk({tag, "_vidx"}, 64'(vec_idx), 64'd0);
    chk({tag, "_cnt"}, 64'(cap_count), 64'd0);
    chk({tag, "_sig"}, 64'(signature), 64'hFFFF_FFFF);
    last_sig_m = 32'hFFFF_FFFF;
    last_cnt_m = 0;
  endtask

  task automatic load(input int a, input logic [IN_W-1:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = AW'(a); load_data = d;
    tbl_m[a] = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // One run: abort sampled at edge t+ab_cyc, a busy-time write at t+poke_cyc,
  // optional table write issued in the same cycle as start.
  task automatic run(input int nv, input int lp, input int ab_cyc, input int poke_cyc,
                     input bit ld, input int ld_a, input logic [IN_W-1:0] ld_d);
    int nl, total, ncap, k, v;
    bit live;
    logic [31:0] msig;
    nl = (lp == 0) ? 1 : lp;
    total = nv * nl * (SETTLE + 1);
    msig = 32'hFFFF_FFFF;
    ncap = 0;
    @(negedge clk);
    start = 1'b1; num_vec = (AW+1)'(nv); loops = LOOP_W'(lp);
    if (ld) begin
      load_we = 1'b1; load_addr = AW'(ld_a); load_data = ld_d;
      tbl_m[ld_a] = ld_d;
    end
    @(negedge clk);
    start = 1'b0; load_we = 1'b0;
    num_vec = (AW+1)'($urandom); loops = LOOP_W'($urandom);
    for (int cyc = 1; cyc <= total + 2 && cyc <= ab_cyc + 2; cyc++) begin
      abort = (cyc == ab_cyc);
      load_we = (cyc == poke_cyc);
      load_addr = '0;
      load_data = ~tbl_m[0];
      @(negedge clk);
      live = (cyc < ab_cyc);
      k = (cyc - 1) / (SETTLE + 1);
      if (live && cyc <= total && (cyc % (SETTLE + 1)) == 0) begin
        v = ((cyc / (SETTLE + 1)) - 1) % nv;
        chk("cap_valid", 64'(cap_valid), 64'd1);
        chk("cap_data", 64'(cap_data), 64'(bench_f(tbl_m[v])));
        msig = sw_misr(msig, bench_f(tbl_m[v]));
        ncap++;
      end else begin
        chk("cap_idle", 64'(cap_valid), 64'd0);
      end
      if (live && cyc <= total) begin
        chk("dut_in", 64'(dut_in), 64'(tbl_m[k % nv]));
        chk("vec_idx", 64'(vec_idx), 64'(k % nv));
      end
      chk("busy", 64'(busy), 64'(live && cyc <= total));
      chk("done", 64'(done), 64'(live && cyc == total + 1));
      chk("cap_count", 64'(cap_count), 64'(ncap));
    end
    abort = 1'b0; load_we = 1'b0;
    chk("signature", 64'(signature), 64'(msig));
    last_sig_m = msig;
    last_cnt_m = ncap;
  endtask

  task automatic reject(input int nv, input bit ab);
    @(negedge clk);
    start = 1'b1; abort = ab; num_vec = (AW+1)'(nv); loops = LOOP_W'(1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rej_busy", 64'(busy), 64'd0);
      chk("rej_capv", 64'(cap_valid), 64'd0);
    end
    chk("rej_sig", 64'(signature), 64'(last_sig_m));
    chk("rej_cnt", 64'(cap_count), 64'(last_cnt_m));
  endtask

  initial begin
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; abort = 1'b0; num_vec = '0; loops = '0;
    #12;
    rst_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(i, IN_W'({$urandom, $urandom}));
    run(8, 1, NO, NO, 1'b0, 0, '0);
    run(3, 4, NO, NO, 1'b0, 0, '0);
    run(8, 1, NO, NO, 1'b0, 0, '0);
    load(5, tbl_m[5] ^ IN_W'(48'h1 << $urandom_range(0, IN_W - 1)));
    run(8, 1, NO, NO, 1'b0, 0, '0);
    // Abort lands in the WAIT of the fifth vector, after four captures.
    run(8, 2, 18, NO, 1'b0, 0, '0);
    run(2, 0, NO, NO, 1'b0, 0, '0);
    reject(0, 1'b0);
    reject(DEPTH + 1, 1'b0);
    reject(4, 1'b1);
    run(4, 2, NO, 6, 1'b0, 0, '0);
    run(4, 1, NO, NO, 1'b0, 0, '0);
    run(5, 1, NO, NO, 1'b1, 4, IN_W'({$urandom, $urandom}));

    for (int r = 0; r < 4; r++) begin
      load($urandom_range(0, DEPTH - 1), IN_W'({$urandom, $urandom}));
      run($urandom_range(1, DEPTH), $urandom_range(0, 3), NO, NO, 1'b0, 0, '0);
    end

    @(negedge clk);
    start = 1'b1; num_vec = 4'd8; loops = 16'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_chk("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run(8, 1, NO, NO, 1'b0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
